// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared constants and command typedef for the shift-add multiplier datapath
//
// Contents:
//   WIDTH_DEF   default operand width
//   CW_DEF      default counter width, clog2(WIDTH)+1
//   REG_W_DEF   working register width, 2*WIDTH+1
//   PROD_W_DEF  product width, 2*WIDTH
//   cmd_t       sequencer command vector {reset, add, shift, decrement}
//   cw_for()    counter width for a given operand width

package mult_pkg;

    localparam int WIDTH_DEF  = 8;
    localparam int CW_DEF     = $clog2(WIDTH_DEF) + 1;
    localparam int REG_W_DEF  = 2 * WIDTH_DEF + 1;
    localparam int PROD_W_DEF = 2 * WIDTH_DEF;

    typedef struct packed {
        logic reset;
        logic add;
        logic shift;
        logic decrement;
    } cmd_t;

    function automatic int cw_for(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/multiplier_datapath_if.sv
// rtl/multiplier_datapath_if.sv - sequencer/datapath bundle for the shift-add multiplier
//
// Signals:
//   RESET, ADD, SHIFT, DECREMENT  sequencer commands
//   READY                         sequencer done indication
//   multiplicand, multiplier      operands (WIDTH bits)
//   register                      working register (2*WIDTH+1 bits)
//   count                         remaining-iteration counter (CW bits)
//   product, product_valid        latched result and its valid flag
//   cmd_error                     sticky illegal-command flag
// Modports: master drives commands/operands (sequencer side), slave is the datapath.

interface multiplier_datapath_if
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CW    = cw_for(WIDTH)
) ();

    logic                 RESET;
    logic                 ADD;
    logic                 SHIFT;
    logic                 DECREMENT;
    logic                 READY;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic [2*WIDTH:0]     register;
    logic [CW-1:0]        count;
    logic [2*WIDTH-1:0]   product;
    logic                 product_valid;
    logic                 cmd_error;

    modport master (
        output RESET, ADD, SHIFT, DECREMENT, READY, multiplicand, multiplier,
        input  register, count, product, product_valid, cmd_error
    );

    modport slave (
        input  RESET, ADD, SHIFT, DECREMENT, READY, multiplicand, multiplier,
        output register, count, product, product_valid, cmd_error
    );

endinterface

// File: rtl/mult_counter.sv
// rtl/mult_counter.sv - iteration counter with load, saturating decrement and zero flag
//
// Ports:
//   clk, n_reset  clock and asynchronous active-low reset
//   load          load WIDTH-1 (start of a multiply)
//   dec           decrement by one, saturating at zero
//   count         current counter value
//   at_zero       count is zero

module mult_counter
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CW    = cw_for(WIDTH)
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic          load,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          at_zero
);

    assign at_zero = (count == '0);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(WIDTH - 1);
        end else if (dec && !at_zero) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/multiplier_datapath.sv
// rtl/multiplier_datapath.sv - shift-add multiplier datapath driven by an external sequencer
//
// Ports:
//   clk       rising-edge clock
//   n_reset   asynchronous active-low reset
//   bus       multiplier_datapath_if.slave: commands, operands, register, count,
//             product/product_valid and sticky cmd_error
//
// RESET loads the multiplier into the low half and takes precedence over the
// ADD/SHIFT/DECREMENT group, whose members act together in one cycle.

module multiplier_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CW    = cw_for(WIDTH)
) (
    input  logic                 clk,
    input  logic                 n_reset,
    multiplier_datapath_if.slave bus
);

    cmd_t               cmd;
    logic [2*WIDTH:0]   reg_q;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] product_q;
    logic               product_valid_q;
    logic               cmd_error_q;
    logic [CW-1:0]      count;
    logic               at_zero;
    logic               any_op;
    logic               illegal;

    assign cmd = {bus.RESET, bus.ADD, bus.SHIFT, bus.DECREMENT};

    // The carry bit of the accumulator is not fed back into the sum: each add
    // starts from the W-bit upper half, and the carry is absorbed by the shift.
    assign sum = {1'b0, reg_q[2*WIDTH-1:WIDTH]} + {1'b0, bus.multiplicand};

    assign any_op  = cmd.add | cmd.shift | cmd.decrement;
    assign illegal = (cmd.reset & any_op)
                   | (any_op & bus.READY)
                   | (cmd.decrement & at_zero & ~cmd.shift);

    mult_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_counter (
        .clk     (clk),
        .n_reset (n_reset),
        .load    (cmd.reset),
        .dec     (cmd.decrement & ~cmd.reset),
        .count   (count),
        .at_zero (at_zero)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            reg_q <= '0;
        end else if (cmd.reset) begin
            reg_q <= {{(WIDTH+1){1'b0}}, bus.multiplier};
        end else if (cmd.add && cmd.shift) begin
            // {sum, low} >> 1 with zero fill at the MSB
            reg_q <= {1'b0, sum, reg_q[WIDTH-1:1]};
        end else if (cmd.add) begin
            reg_q[2*WIDTH:WIDTH] <= sum;
        end else if (cmd.shift) begin
            reg_q <= {1'b0, reg_q[2*WIDTH:1]};
        end
    end

    // Capture happens once per run: product_valid blocks re-capture until RESET.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            product_q       <= '0;
            product_valid_q <= 1'b0;
        end else if (cmd.reset) begin
            product_valid_q <= 1'b0;
        end else if (!product_valid_q && bus.READY) begin
            product_q       <= reg_q[2*WIDTH-1:0];
            product_valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cmd_error_q <= 1'b0;
        end else if (illegal) begin
            cmd_error_q <= 1'b1;
        end
    end

    assign bus.register      = reg_q;
    assign bus.count         = count;
    assign bus.product       = product_q;
    assign bus.product_valid = product_valid_q;
    assign bus.cmd_error     = cmd_error_q;

endmodule

// File: tb/tb_multiplier_datapath.sv
// tb/tb_multiplier_datapath.sv - self-checking bench for multiplier_datapath

module tb_multiplier_datapath;
    import mult_pkg::*;

    localparam int W  = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic n_reset;

    always #5 clk = ~clk;

    multiplier_datapath_if #(.WIDTH(W), .CW(CW)) bus ();

    multiplier_datapath #(.WIDTH(W), .CW(CW)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle;
        bus.RESET     = 1'b0;
        bus.ADD       = 1'b0;
        bus.SHIFT     = 1'b0;
        bus.DECREMENT = 1'b0;
        bus.READY     = 1'b0;
    endtask

    // Reference: the result is a*b, and count is a saturating countdown from W-1.
    task automatic run_mult(input int a, input int b, input bit chk_count, input bit exp_err);
        int ec;
        int exp_prod;
        exp_prod = (a * b) & 16'hFFFF;
        idle();
        bus.multiplier   = W'(a);
        bus.multiplicand = W'(b);
        bus.RESET        = 1'b1;
        tick();
        bus.RESET = 1'b0;
        check("load_register", 64'(bus.register), 64'(a));
        check("load_count", 64'(bus.count), 64'(W - 1));
        check("load_pv", 64'(bus.product_valid), 64'd0);
        ec = W - 1;
        for (int i = 0; i < W; i++) begin
            bus.ADD       = bus.register[0];
            bus.SHIFT     = 1'b1;
            bus.DECREMENT = 1'b1;
            tick();
            ec = (ec > 0) ? ec - 1 : 0;
            if (chk_count) check($sformatf("count_iter%0d", i), 64'(bus.count), 64'(ec));
        end
        idle();
        bus.READY = 1'b1;
        tick();
        check($sformatf("product_%0dx%0d", a, b), 64'(bus.product), 64'(exp_prod));
        check("product_valid", 64'(bus.product_valid), 64'd1);
        tick();
        check("product_hold_ready", 64'(bus.product), 64'(exp_prod));
        bus.READY = 1'b0;
        tick();
        check("product_hold_after", 64'(bus.product), 64'(exp_prod));
        check("pv_hold_after", 64'(bus.product_valid), 64'd1);
        check("cmd_error_run", 64'(bus.cmd_error), 64'(exp_err));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_register"}, 64'(bus.register), 64'd0);
        check({tag, "_count"}, 64'(bus.count), 64'd0);
        check({tag, "_product"}, 64'(bus.product), 64'd0);
        check({tag, "_pv"}, 64'(bus.product_valid), 64'd0);
        check({tag, "_err"}, 64'(bus.cmd_error), 64'd0);
    endtask

    task automatic pulse_nreset;
        n_reset = 1'b0;
        #2;
        n_reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int a;
        int b;
        n_reset = 1'b0;
        bus.multiplier   = '0;
        bus.multiplicand = '0;
        idle();
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        n_reset = 1'b1;
        @(negedge clk);

        run_mult(11, 13, 1'b0, 1'b0);
        run_mult(255, 255, 1'b0, 1'b0);
        run_mult(0, 200, 1'b1, 1'b0);

        // Directed single commands, including the accumulator carry bit.
        bus.multiplier = '0;
        bus.RESET = 1'b1;
        tick();
        idle();
        bus.multiplicand = 8'd255;
        bus.ADD = 1'b1;
        tick();
        check("add_only_1", 64'(bus.register), 64'h0FF00);
        tick();
        check("add_only_carry", 64'(bus.register), 64'h1FE00);
        idle();
        bus.SHIFT = 1'b1;
        tick();
        check("shift_only", 64'(bus.register), 64'h0FF00);
        idle();
        tick();
        check("hold_register", 64'(bus.register), 64'h0FF00);
        check("hold_count", 64'(bus.count), 64'd7);
        bus.DECREMENT = 1'b1;
        tick();
        check("dec_only", 64'(bus.count), 64'd6);
        idle();

        // Abort mid-multiply: n_reset low for 3 ns inside the 4th iteration.
        bus.multiplier   = 8'd200;
        bus.multiplicand = 8'd100;
        bus.RESET = 1'b1;
        tick();
        bus.RESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.ADD       = bus.register[0];
            bus.SHIFT     = 1'b1;
            bus.DECREMENT = 1'b1;
            if (i < 3) tick();
        end
        #1;
        n_reset = 1'b0;
        #1;
        check_all_zero("abort");
        #2;
        n_reset = 1'b1;
        tick();
        idle();
        run_mult(6, 7, 1'b0, 1'b0);

        for (int k = 0; k < 4; k++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            run_mult(a, b, 1'b0, 1'b0);
        end

        // RESET together with ADD: error, load still happens.
        bus.multiplier   = 8'hA5;
        bus.multiplicand = 8'h33;
        bus.RESET = 1'b1;
        bus.ADD   = 1'b1;
        tick();
        idle();
        check("reset_add_err", 64'(bus.cmd_error), 64'd1);
        check("reset_add_register", 64'(bus.register), 64'h000A5);
        run_mult(5, 9, 1'b0, 1'b1);

        pulse_nreset();
        check("err_cleared", 64'(bus.cmd_error), 64'd0);
        bus.READY = 1'b1;
        bus.SHIFT = 1'b1;
        tick();
        idle();
        check("ready_shift_err", 64'(bus.cmd_error), 64'd1);

        pulse_nreset();
        bus.DECREMENT = 1'b1;
        bus.SHIFT     = 1'b1;
        tick();
        idle();
        check("dec_shift_zero_noerr", 64'(bus.cmd_error), 64'd0);
        check("dec_zero_saturate", 64'(bus.count), 64'd0);
        bus.DECREMENT = 1'b1;
        tick();
        idle();
        check("dec_zero_err", 64'(bus.cmd_error), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
